fetch_stage: RTL and testbench
==============================

# fetch_stage

- Owns the PC register and the IF/ID pipeline register of the five-stage MIPS core.
- Each cycle it takes the next-PC value chosen by the NPC mux and issues the current PC to instruction memory over a req/valid handshake.
- It supplies `pc_plus4F` back to the NPC mux and delivers `{instrD, pc_plus4D, validD}` to decode.
- It absorbs memory wait states, hazard-unit stalls and branch/jump flushes, including a flush that lands while a fetch is still outstanding.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset; synchronous, active-low.
- npc  in  32  next PC from the NPC mux.
- stallD  in  1  hazard-unit stall; holds both PC and IF/ID.
- flushD  in  1  squash IF/ID and the in-flight fetch; ignored while stallD=1.
- imem_req  out  1  fetch request, held high until accepted.
- imem_addr  out  32  equals pcF.
- imem_rdata  in  32  instruction word; meaningful only with imem_valid.
- imem_valid  in  1  response strobe.
- pcF  out  32  current fetch PC.
- pc_plus4F  out  32  pcF + 4, modulo 2^32.
- imem_stall  out  1  fetch waiting on memory, to the hazard unit.
- instrD  out  32  decode instruction.
- pc_plus4D  out  32  decode PC + 4.
- validD  out  1  instrD is a real instruction (0 = bubble).

## Operation
- States:
  - FETCH: request outstanding.
  - HOLD: response captured but decode stalled.
- imem_req = (state==FETCH) & rst. imem_valid is accepted in the same cycle as the request (zero-wait) or any later cycle. imem_valid while imem_req=0 is ignored.
- Completion in FETCH: imem_valid=1.
  - If stallD=0: IF/ID <= {imem_rdata, pc_plus4F, 1}, pcF <= npc, stay in FETCH.
  - If stallD=1: capture {imem_rdata, pc_plus4F} in the hold buffer, go to HOLD, keep pcF.
- FETCH with no response:
  - imem_stall=1 and pcF holds.
  - If stallD=0: IF/ID <= bubble {32'h0, 32'h0, 0}.
  - If stallD=1: IF/ID holds.
- HOLD:
  - If stallD=0: IF/ID <= hold buffer with validD=1, pcF <= npc, go to FETCH.
  - Otherwise, hold.
- flushD=1 with stallD=0 always loads a bubble into IF/ID. It then depends on where the fetch is:
  - Completing this cycle, or in HOLD: the fetched word is discarded, pcF <= npc, go to FETCH.
  - Outstanding, no response yet: latch redir_pc <= npc and set redir_pend. When the response arrives, discard it, pcF <= redir_pc, clear redir_pend, stay in FETCH.
- A second flushD while redir_pend=1 overwrites redir_pc.
- Any response received while redir_pend=1 never reaches IF/ID.

## Timing
- Values after rst=0 at a clock edge:
  - pcF = RESET_PC, state = FETCH
  - IF/ID = bubble, redir_pend = 0
  - imem_req = 0 while rst=0
- First request is issued in the first cycle with rst=1.
- Zero-wait memory: one instruction per cycle. instrD appears on the edge after its request cycle.
- N wait cycles give N bubbles, with imem_stall high for N cycles.
- pc_plus4F and imem_addr follow pcF combinationally. npc is sampled only on the edge where pcF updates.
- Reset mid-fetch abandons the request. Any imem_valid arriving afterwards that does not match a new request is the memory's responsibility; this block treats the first imem_valid after reset as the RESET_PC response.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_wait_cnt[31:0] and perf_kill_cnt[31:0].
  - perf_wait_cnt increments each cycle imem_stall=1.
  - perf_kill_cnt increments per discarded fetched word.
  - Both counters wrap, and both clear on reset.
- FETCH_PERF_EN undefined: neither the ports nor the logic exist.

## Structure
- Shared mips_pkg holds:
  - the fetch_state_t enum (FETCH, HOLD)
  - NOP_INSTR = 32'h0
  - the default RESET_PC constant
- One sub-module, ifid_reg: the IF/ID register with load, hold and bubble controls. Instantiated once.

## Test plan
- Reset with zero-wait memory, npc = pc_plus4F: imem_addr is 0, 4, 8 on consecutive cycles. instrD matches one cycle later with validD=1.
- imem_valid delayed 3 cycles at PC 0x10: imem_stall high for 3 cycles, 3 bubbles in decode, then instrD = word@0x10.
- stallD=1 for 2 cycles as word@0x20 returns: state goes to HOLD, pcF stays 0x20. On release, instrD = word@0x20 and pcF = npc.
- flushD with npc=0x100 while the fetch of 0x24 waits 2 cycles: validD=0. Word@0x24 is discarded, the next request is to 0x100, and perf_kill_cnt=1 when FETCH_PERF_EN is defined.
- flushD on a completing zero-wait fetch: no valid instruction from the old PC reaches decode, and the next imem_addr = npc.
- rst=0 during an outstanding request: imem_req drops. After release, pcF=RESET_PC, validD=0, and both counters are 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: fetch FSM states and fetch constants.
package mips_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
// Bubble takes priority over load; neither asserted means hold.
module ifid_reg
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            bubble,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_plus4,
    output logic            valid
);

    // Register update: reset/bubble, load a real instruction, or hold
    always_ff @(posedge clk) begin
        if (!rst || bubble) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (load) begin
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage of the five-stage MIPS core: PC register, imem req/valid
// handshake, hold buffer for stalled responses, and flush redirection
// for fetches still outstanding when the flush arrives.
// Optional macro FETCH_PERF_EN adds wait/kill performance counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] npc,
    input  logic            stallD,
    input  logic            flushD,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] pcF,
    output logic [XLEN-1:0] pc_plus4F,
    output logic            imem_stall,
    output logic [XLEN-1:0] instrD,
    output logic [XLEN-1:0] pc_plus4D,
    output logic            validD
`ifdef FETCH_PERF_EN
    ,
    output logic [XLEN-1:0] perf_wait_cnt,
    output logic [XLEN-1:0] perf_kill_cnt
`endif
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc_q, pc_next;
    logic [XLEN-1:0] hold_instr, hold_pc4;
    logic            hold_load;
    logic [XLEN-1:0] redir_pc, redir_pc_next;
    logic            redir_pend, redir_pend_next;
    logic            ifid_load, ifid_bubble;
    logic [XLEN-1:0] ifid_instr_in, ifid_pc4_in;
    logic            resp;
    logic            flush_eff;

    assign imem_req   = (state == FETCH) & rst;
    assign imem_addr  = pc_q;
    assign pcF        = pc_q;
    assign pc_plus4F  = pc_q + XLEN'(4);
    assign imem_stall = imem_req & ~imem_valid;
    assign resp       = imem_req & imem_valid;
    assign flush_eff  = flushD & ~stallD;

    // State, PC and redirect registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= FETCH;
            pc_q       <= RESET_PC;
            redir_pc   <= RESET_PC;
            redir_pend <= 1'b0;
        end else begin
            state      <= state_next;
            pc_q       <= pc_next;
            redir_pc   <= redir_pc_next;
            redir_pend <= redir_pend_next;
        end
    end

    // Hold buffer: captures a response that decode cannot take yet
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_instr <= NOP_INSTR;
            hold_pc4   <= '0;
        end else if (hold_load) begin
            hold_instr <= imem_rdata;
            hold_pc4   <= pc_plus4F;
        end
    end

    // Next-state, PC, redirect and IF/ID control decisions
    always_comb begin
        state_next      = state;
        pc_next         = pc_q;
        redir_pc_next   = redir_pc;
        redir_pend_next = redir_pend;
        hold_load       = 1'b0;
        ifid_load       = 1'b0;
        ifid_bubble     = 1'b0;
        ifid_instr_in   = imem_rdata;
        ifid_pc4_in     = pc_plus4F;

        case (state)
            FETCH: begin
                if (redir_pend) begin
                    // Outstanding fetch is stale; its response is dropped
                    if (!stallD) ifid_bubble = 1'b1;
                    if (resp) begin
                        redir_pend_next = 1'b0;
                        pc_next         = flush_eff ? npc : redir_pc;
                    end else if (flush_eff) begin
                        redir_pc_next = npc;
                    end
                end else if (resp) begin
                    if (flush_eff) begin
                        ifid_bubble = 1'b1;
                        pc_next     = npc;
                    end else if (!stallD) begin
                        ifid_load = 1'b1;
                        pc_next   = npc;
                    end else begin
                        hold_load  = 1'b1;
                        state_next = HOLD;
                    end
                end else begin
                    if (!stallD) ifid_bubble = 1'b1;
                    if (flush_eff) begin
                        redir_pc_next   = npc;
                        redir_pend_next = 1'b1;
                    end
                end
            end
            HOLD: begin
                ifid_instr_in = hold_instr;
                ifid_pc4_in   = hold_pc4;
                if (flush_eff) begin
                    ifid_bubble = 1'b1;
                    pc_next     = npc;
                    state_next  = FETCH;
                end else if (!stallD) begin
                    ifid_load  = 1'b1;
                    pc_next    = npc;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end

    ifid_reg u_ifid (
        .clk         (clk),
        .rst         (rst),
        .load        (ifid_load),
        .bubble      (ifid_bubble),
        .instr_in    (ifid_instr_in),
        .pc_plus4_in (ifid_pc4_in),
        .instr       (instrD),
        .pc_plus4    (pc_plus4D),
        .valid       (validD)
    );

`ifdef FETCH_PERF_EN
    logic kill;

    // A fetched word is discarded by a pending redirect, a flush on completion, or a flush in HOLD
    assign kill = (resp & (redir_pend | flush_eff)) | ((state == HOLD) & flush_eff);

    // Wrapping performance counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_wait_cnt <= '0;
            perf_kill_cnt <= '0;
        end else begin
            if (imem_stall) perf_wait_cnt <= perf_wait_cnt + XLEN'(1);
            if (kill)       perf_kill_cnt <= perf_kill_cnt + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed handshake scenarios with a
// scoreboard of instructions expected to reach decode.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] npc;
    logic        stallD;
    logic        flushD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] pcF;
    logic [31:0] pc_plus4F;
    logic        imem_stall;
    logic [31:0] instrD;
    logic [31:0] pc_plus4D;
    logic        validD;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_wait_cnt;
    logic [31:0] perf_kill_cnt;
`endif

    logic        npc_sel;
    logic [31:0] npc_ovr;
    logic        stall_edge = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // NPC mux model: sequential by default, override for jumps/flushes
    assign npc        = npc_sel ? npc_ovr : pc_plus4F;
    assign imem_rdata = word(imem_addr);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .npc        (npc),
        .stallD     (stallD),
        .flushD     (flushD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .pcF        (pcF),
        .pc_plus4F  (pc_plus4F),
        .imem_stall (imem_stall),
        .instrD     (instrD),
        .pc_plus4D  (pc_plus4D),
        .validD     (validD)
`ifdef FETCH_PERF_EN
        ,
        .perf_wait_cnt (perf_wait_cnt),
        .perf_kill_cnt (perf_kill_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] a);
        exp_q.push_back({word(a), a + 32'd4});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic f);
        imem_valid = v;
        stallD     = s;
        flushD     = f;
        #1;
    endtask

    // IF/ID only changes on edges where stallD was low
    always @(posedge clk) stall_edge = stallD;

    // Scoreboard: every new valid decode instruction must match the queue head
    always @(negedge clk) begin
        if (rst && validD && !stall_edge) begin
            if (exp_q.size() == 0) begin
                check("sb_depth", 32'(exp_q.size()), 32'd1);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                check("instrD", instrD, e[63:32]);
                check("pc_plus4D", pc_plus4D, e[31:0]);
            end
        end
    end

    initial begin
        rst     = 1'b0;
        npc_sel = 1'b0;
        npc_ovr = 32'h0;
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) cyc();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_pcF", pcF, 32'h0);
        check("rst_validD", 32'(validD), 32'd0);
`ifdef FETCH_PERF_EN
        check("rst_wait_cnt", perf_wait_cnt, 32'd0);
        check("rst_kill_cnt", perf_kill_cnt, 32'd0);
`endif

        // Zero-wait stream from reset
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        check("first_req", 32'(imem_req), 32'd1);
        for (int i = 0; i < 4; i++) begin
            check("addr_seq", imem_addr, 32'(4 * i));
            expect_word(32'(4 * i));
            cyc();
        end

        // Three wait states at 0x10
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0);
            check("wait_stall", 32'(imem_stall), 32'd1);
            cyc();
            check("wait_bubble", 32'(validD), 32'd0);
            check("wait_pc", pcF, 32'h10);
        end
        drive(1'b1, 1'b0, 1'b0);
        check("wait_done_stall", 32'(imem_stall), 32'd0);
        expect_word(32'h10);
        cyc();
        for (int i = 0; i < 3; i++) begin
            expect_word(32'h14 + 32'(4 * i));
            cyc();
        end
        check("pc_at_20", pcF, 32'h20);

        // Decode stall as word@0x20 returns
        drive(1'b1, 1'b1, 1'b0);
        cyc();
        check("hold_pc", pcF, 32'h20);
        check("hold_req", 32'(imem_req), 32'd0);
        drive(1'b0, 1'b1, 1'b0);
        cyc();
        check("hold_pc2", pcF, 32'h20);
        check("hold_ifid", instrD, word(32'h1C));
        drive(1'b0, 1'b0, 1'b0);
        expect_word(32'h20);
        cyc();
        check("release_pc", pcF, 32'h24);

        // Flush to 0x100 while fetch of 0x24 waits two cycles
        npc_sel = 1'b1;
        npc_ovr = 32'h100;
        drive(1'b0, 1'b0, 1'b1);
        check("flush_stall", 32'(imem_stall), 32'd1);
        check("pc_plus4F", pc_plus4F, 32'h28);
        cyc();
        check("flush_validD", 32'(validD), 32'd0);
        check("flush_pc_held", pcF, 32'h24);
        npc_sel = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        check("flush_addr_out", imem_addr, 32'h24);
        cyc();
        check("flush_validD2", 32'(validD), 32'd0);
        drive(1'b1, 1'b0, 1'b0);
        cyc();
        check("redir_pc", pcF, 32'h100);
        check("redir_validD", 32'(validD), 32'd0);
`ifdef FETCH_PERF_EN
        check("kill_cnt1", perf_kill_cnt, 32'd1);
        check("wait_cnt5", perf_wait_cnt, 32'd5);
`endif

        // Flush on a completing zero-wait fetch
        npc_sel = 1'b1;
        npc_ovr = 32'h200;
        drive(1'b1, 1'b0, 1'b1);
        cyc();
        check("cflush_validD", 32'(validD), 32'd0);
        check("cflush_addr", imem_addr, 32'h200);
        npc_sel = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        expect_word(32'h200);
        cyc();
        check("cflush_next", pcF, 32'h204);

        // Second flush overwrites the pending redirect; target wraps pc_plus4F
        npc_sel = 1'b1;
        npc_ovr = 32'h300;
        drive(1'b0, 1'b0, 1'b1);
        cyc();
        npc_ovr = 32'hFFFF_FFFC;
        drive(1'b0, 1'b0, 1'b1);
        cyc();
        npc_sel = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        cyc();
        check("dflush_pc", pcF, 32'hFFFF_FFFC);
        check("dflush_validD", 32'(validD), 32'd0);
        check("pc_plus4F_wrap", pc_plus4F, 32'h0);
`ifdef FETCH_PERF_EN
        check("kill_cnt3", perf_kill_cnt, 32'd3);
        check("wait_cnt7", perf_wait_cnt, 32'd7);
`endif

        // Reset during an outstanding request
        drive(1'b0, 1'b0, 1'b0);
        cyc();
        rst = 1'b0;
        #1;
        check("midrst_req", 32'(imem_req), 32'd0);
        cyc();
        check("midrst_pc", pcF, 32'h0);
        check("midrst_validD", 32'(validD), 32'd0);
`ifdef FETCH_PERF_EN
        check("midrst_wait", perf_wait_cnt, 32'd0);
        check("midrst_kill", perf_kill_cnt, 32'd0);
`endif
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        check("post_rst_addr", imem_addr, 32'h0);
        expect_word(32'h0);
        cyc();
        check("post_rst_pc", pcF, 32'h4);
        drive(1'b0, 1'b0, 1'b0);
        cyc();
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
